dbg_inject_seq: RTL and testbench

//  Sequencer for the logic-analyzer override mux. Arms on a command, waits for a

---
 rtl/dbg_inject_seq.sv | 152 +++++++++++++++
 tb/tb_dbg_inject_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_inject_seq.sv
// Override-injection sequencer for the logic-analyzer mux: arm, trigger on a probe bit,
// delay, then drive override enable/data for a programmed length; snapshots probe at trigger.
module dbg_inject_seq #(
  parameter int unsigned W     = 128,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SEL_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_arm_i,
  input  logic             cfg_abort_i,
  input  logic [W-1:0]     cfg_mask_i,
  input  logic [W-1:0]     cfg_data_i,
  input  logic [1:0]       cfg_trig_sel_i,
  input  logic [SEL_W-1:0] cfg_trig_bit_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic [W-1:0]     probe_i,
  output logic [W-1:0]     oenb_o,
  output logic [W-1:0]     data_o,
  output logic [W-1:0]     snap_o,
  output logic             snap_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_INJECT, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_mask, r_data, r_oenb, r_dout, r_snap;
  logic [1:0]       r_sel;
  logic [SEL_W-1:0] r_bit, w_prev_idx;
  logic [CNT_W-1:0] r_delay, r_len;
  logic             r_prev, r_snap_valid;
  logic             w_arm_ok, w_trig, w_bit, w_bit_ok, w_prev_nxt;

  assign w_arm_ok = cfg_arm_i && !cfg_abort_i &&
                    (r_state == S_IDLE || r_state == S_DONE);

  // prev_bit follows the newly latched index from the arm cycle on, so an edge
  // in the arm cycle itself cannot be mistaken for a trigger in the first ARMED cycle.
  always_comb begin
    w_prev_idx = w_arm_ok ? cfg_trig_bit_i : r_bit;
    w_prev_nxt = 1'b0;
    if (32'(w_prev_idx) < W) w_prev_nxt = probe_i[w_prev_idx];
    w_bit_ok = (32'(r_bit) < W);
    w_bit    = 1'b0;
    if (w_bit_ok) w_bit = probe_i[r_bit];
  end

  always_comb begin
    w_trig = 1'b0;
    case (r_sel)
      2'd0: w_trig = 1'b1;
      2'd1: w_trig = w_bit_ok && w_bit && !r_prev;
      2'd2: w_trig = w_bit_ok && !w_bit && r_prev;
      2'd3: w_trig = w_bit_ok && w_bit;
      default: w_trig = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    case (r_state)
      S_ARMED: begin
        if (w_trig) begin
          if (r_delay != '0) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = r_delay - CNT_W'(1);
          end else if (r_len != '0) begin
            w_state_nxt = S_INJECT;
            w_cnt_nxt   = r_len - CNT_W'(1);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DELAY: begin
        if (r_cnt == '0) begin
          if (r_len != '0) begin
            w_state_nxt = S_INJECT;
            w_cnt_nxt   = r_len - CNT_W'(1);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_INJECT: if (r_cnt == '0) w_state_nxt = S_DONE;
      default: ;
    endcase
    if (w_arm_ok) begin
      w_state_nxt = S_ARMED;
      w_cnt_nxt   = '0;
    end
    if (cfg_abort_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // Override outputs are registered from next-state so they line up exactly with INJECT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_data       <= '0;
      r_sel        <= '0;
      r_bit        <= '0;
      r_delay      <= '0;
      r_len        <= '0;
      r_prev       <= 1'b0;
      r_oenb       <= '1;
      r_dout       <= '0;
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= w_prev_nxt;
      r_oenb  <= (w_state_nxt == S_INJECT) ? ~r_mask : '1;
      r_dout  <= (w_state_nxt == S_INJECT) ? (r_data & r_mask) : '0;
      if (w_arm_ok) begin
        r_mask       <= cfg_mask_i;
        r_data       <= cfg_data_i;
        r_sel        <= cfg_trig_sel_i;
        r_bit        <= cfg_trig_bit_i;
        r_delay      <= cfg_delay_i;
        r_len        <= cfg_len_i;
        r_snap_valid <= 1'b0;
      end
      if (r_state == S_ARMED && w_trig && !cfg_abort_i) begin
        r_snap       <= probe_i;
        r_snap_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    oenb_o       = r_oenb;
    data_o       = r_dout;
    snap_o       = r_snap;
    snap_valid_o = r_snap_valid;
    busy_o       = (r_state == S_ARMED) || (r_state == S_DELAY) || (r_state == S_INJECT);
    done_o       = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_dbg_inject_seq.sv
// Directed bench for dbg_inject_seq: a per-cycle vector table for the basic sequence,
// then hand-written sequences for trigger modes, reset, abort, re-arm and long delay.
module tb_dbg_inject_seq;
  localparam int unsigned W = 128;
  localparam logic [W-1:0] ONES = '1;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cfg_arm_i, cfg_abort_i;
  logic [W-1:0]   cfg_mask_i, cfg_data_i;
  logic [1:0]     cfg_trig_sel_i;
  logic [6:0]     cfg_trig_bit_i;
  logic [15:0]    cfg_delay_i, cfg_len_i;
  logic [W-1:0]   probe_i;
  logic [W-1:0]   oenb_o, data_o, snap_o;
  logic           snap_valid_o, busy_o, done_o;

  dbg_inject_seq #(.W(128), .CNT_W(16), .SEL_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_arm_i(cfg_arm_i), .cfg_abort_i(cfg_abort_i),
    .cfg_mask_i(cfg_mask_i), .cfg_data_i(cfg_data_i),
    .cfg_trig_sel_i(cfg_trig_sel_i), .cfg_trig_bit_i(cfg_trig_bit_i),
    .cfg_delay_i(cfg_delay_i), .cfg_len_i(cfg_len_i),
    .probe_i(probe_i),
    .oenb_o(oenb_o), .data_o(data_o), .snap_o(snap_o),
    .snap_valid_o(snap_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         arm;
    logic         abort;
    logic [W-1:0] probe;
    logic [W-1:0] e_oenb;
    logic [W-1:0] e_data;
    logic         e_busy;
    logic         e_done;
    logic         e_sv;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(logic arm, logic abort, logic [W-1:0] probe,
                              logic [W-1:0] eo, logic [W-1:0] ed,
                              logic eb, logic edn, logic esv);
    vec_t v;
    v.arm = arm; v.abort = abort; v.probe = probe;
    v.e_oenb = eo; v.e_data = ed; v.e_busy = eb; v.e_done = edn; v.e_sv = esv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [W-1:0] eo, input logic [W-1:0] ed,
                        input logic eb, input logic edn, input logic esv);
    chk({nm, ".oenb"}, oenb_o, eo);
    chk({nm, ".data"}, data_o, ed);
    chk({nm, ".busy"}, W'(busy_o), W'(eb));
    chk({nm, ".done"}, W'(done_o), W'(edn));
    chk({nm, ".snap_valid"}, W'(snap_valid_o), W'(esv));
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_cfg(input logic [1:0] sel, input logic [6:0] bitx,
                         input logic [15:0] dly, input logic [15:0] len,
                         input logic [W-1:0] mask, input logic [W-1:0] dat);
    cfg_trig_sel_i = sel; cfg_trig_bit_i = bitx;
    cfg_delay_i = dly; cfg_len_i = len;
    cfg_mask_i = mask; cfg_data_i = dat;
  endtask

  task automatic arm_step();
    cfg_arm_i = 1'b1;
    step();
    cfg_arm_i = 1'b0;
  endtask

  localparam logic [W-1:0] P_A  = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
  localparam logic [W-1:0] NM5  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFA;
  localparam logic [W-1:0] M_B  = 128'h00000000_00000000_00000000_0000FF00;
  localparam logic [W-1:0] NM_B = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF00FF;
  localparam logic [W-1:0] P_B  = 128'h00200000_00000000_00000000_0000BEEF;
  localparam logic [W-1:0] D_D  = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

  int n;

  initial begin
    rst_i = 1'b1; cfg_arm_i = 1'b0; cfg_abort_i = 1'b0; probe_i = '0;
    set_cfg(2'd0, 7'd0, 16'd0, 16'd0, '0, '0);
    @(negedge clk_i);
    step(); step();
    rst_i = 1'b0;

    chk_st("reset", ONES, '0, 1'b0, 1'b0, 1'b0);
    chk("reset.snap", snap_o, '0);

    // Table: sel0, delay 0, len 3, mask 0x5, data 0xF; then re-arm and abort vs trigger.
    tbl[0] = mk(1, 0, '0,  ONES, '0,      1, 0, 0);
    tbl[1] = mk(0, 0, P_A, NM5,  128'h5,  1, 0, 1);
    tbl[2] = mk(0, 0, '0,  NM5,  128'h5,  1, 0, 1);
    tbl[3] = mk(0, 0, '0,  NM5,  128'h5,  1, 0, 1);
    tbl[4] = mk(0, 0, '0,  ONES, '0,      0, 1, 1);
    tbl[5] = mk(0, 0, '0,  ONES, '0,      0, 1, 1);
    tbl[6] = mk(1, 0, '0,  ONES, '0,      1, 0, 0);
    tbl[7] = mk(0, 1, '1,  ONES, '0,      0, 0, 0);
    tbl[8] = mk(0, 0, '0,  ONES, '0,      0, 0, 0);
    set_cfg(2'd0, 7'd0, 16'd0, 16'd3, 128'h5, 128'hF);
    for (int i = 0; i < 9; i++) begin
      cfg_arm_i = tbl[i].arm; cfg_abort_i = tbl[i].abort; probe_i = tbl[i].probe;
      step();
      chk_st($sformatf("tbl[%0d]", i), tbl[i].e_oenb, tbl[i].e_data,
             tbl[i].e_busy, tbl[i].e_done, tbl[i].e_sv);
    end
    cfg_arm_i = 1'b0; cfg_abort_i = 1'b0; probe_i = '0;
    chk("tbl.snap", snap_o, P_A);

    // Rising edge on bit 117, delay 4, len 2; edge in the arm cycle must be ignored.
    set_cfg(2'd1, 7'd117, 16'd4, 16'd2, M_B, 128'hA5A5);
    probe_i = '0; probe_i[117] = 1'b1;
    arm_step();
    chk_st("B.armed", ONES, '0, 1'b1, 1'b0, 1'b0);
    step();
    chk_st("B.arm_edge_ignored", ONES, '0, 1'b1, 1'b0, 1'b0);
    probe_i = '0;
    for (int i = 0; i < 8; i++) step();
    chk_st("B.wait", ONES, '0, 1'b1, 1'b0, 1'b0);
    probe_i = P_B;
    step();
    probe_i = '0;
    for (int i = 1; i <= 4; i++) begin
      chk_st($sformatf("B.delay%0d", i), ONES, '0, 1'b1, 1'b0, 1'b1);
      step();
    end
    chk_st("B.inj1", NM_B, 128'hA500, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("B.inj2", NM_B, 128'hA500, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("B.done", ONES, '0, 1'b0, 1'b1, 1'b1);
    chk("B.snap", snap_o, P_B);
    chk("B.snap117", W'(snap_o[117]), W'(1'b1));

    // Falling edge on bit 5, delay 2, len 0: never any override.
    set_cfg(2'd2, 7'd5, 16'd2, 16'd0, ONES, ONES);
    probe_i = '0;
    arm_step();
    chk_st("C.armed", ONES, '0, 1'b1, 1'b0, 1'b0);
    probe_i = 128'h20;
    step();
    chk_st("C.rise_ignored", ONES, '0, 1'b1, 1'b0, 1'b0);
    probe_i = '0;
    step();
    chk_st("C.delay1", ONES, '0, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("C.delay2", ONES, '0, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("C.done", ONES, '0, 1'b0, 1'b1, 1'b1);
    step();
    chk_st("C.hold", ONES, '0, 1'b0, 1'b1, 1'b1);

    // Level-high on bit 0, reset in the middle of INJECT.
    set_cfg(2'd3, 7'd0, 16'd0, 16'd5, ONES, D_D);
    arm_step();
    chk_st("D.armed", ONES, '0, 1'b1, 1'b0, 1'b0);
    probe_i = 128'h1;
    step();
    probe_i = '0;
    chk_st("D.inj1", '0, D_D, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("D.inj2", '0, D_D, 1'b1, 1'b0, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_st("D.reset", ONES, '0, 1'b0, 1'b0, 1'b0);
    chk("D.snap", snap_o, '0);

    // Abort during DELAY: IDLE next cycle, snap_valid kept, no INJECT afterwards.
    set_cfg(2'd0, 7'd0, 16'd3, 16'd2, ONES, ONES);
    arm_step();
    step();
    chk_st("E1.delay", ONES, '0, 1'b1, 1'b0, 1'b1);
    cfg_abort_i = 1'b1;
    step();
    cfg_abort_i = 1'b0;
    chk_st("E1.abort", ONES, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("E1.no_inject%0d", i), oenb_o, ONES);
    end

    // Arm during INJECT is ignored and the new cfg has no effect.
    set_cfg(2'd0, 7'd0, 16'd0, 16'd4, 128'hF, 128'h6);
    arm_step();
    step();
    chk_st("E2.inj1", ~W'(128'hF), 128'h6, 1'b1, 1'b0, 1'b1);
    set_cfg(2'd0, 7'd0, 16'd0, 16'd9, ONES, ONES);
    arm_step();
    chk_st("E2.inj2_arm_ignored", ~W'(128'hF), 128'h6, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("E2.inj3", ~W'(128'hF), 128'h6, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("E2.inj4", ~W'(128'hF), 128'h6, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("E2.done", ONES, '0, 1'b0, 1'b1, 1'b1);

    // Re-arm from DONE with new cfg and the maximum delay.
    set_cfg(2'd0, 7'd0, 16'hFFFF, 16'd1, 128'hF0, ONES);
    arm_step();
    chk_st("F.rearm", ONES, '0, 1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (oenb_o === ONES && n < 70000);
    chk("F.delay_cycles", W'(n), W'(65536));
    chk_st("F.inj", ~W'(128'hF0), 128'hF0, 1'b1, 1'b0, 1'b1);
    step();
    chk_st("F.done", ONES, '0, 1'b0, 1'b1, 1'b1);
    cfg_abort_i = 1'b1;
    step();
    cfg_abort_i = 1'b0;
    chk_st("F.abort", ONES, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
